// File: rtl/bias_bram_reader.sv
// bias_bram_reader
// Read-side sequencer for port A of the bias BRAM (HIGH_PERFORMANCE, 2-cycle
// read latency). A legal start command fetches `count` consecutive words from
// `base_addr`, wrapping at RAM_DEPTH-1, and streams them on a valid/ready
// interface. Words are held in a small first-word-fall-through FIFO so that
// downstream backpressure never drops or reorders data.
//
// Ports:
//   clka, rsta              clock, synchronous active-high reset
//   start, base_addr, count command strobe and arguments (sampled in IDLE)
//   busy, done, err         status: busy span, end-of-command pulse, bad-command pulse
//   bram_addr, bram_en,
//   bram_regce, bram_dout   BRAM port A read interface
//   m_data, m_valid,
//   m_ready, m_last         output stream; m_last marks the final beat
module bias_bram_reader #(
  parameter int RAM_WIDTH  = 40,
  parameter int RAM_DEPTH  = 49,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  bram_regce,
  input  logic [RAM_WIDTH-1:0]  bram_dout,
  output logic [RAM_WIDTH-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   reads_remaining;
  logic [CNT_WIDTH-1:0]   push_idx;
  logic                   tag1;
  logic                   tag2;
  logic [RAM_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic                   fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_ptr_next;
  logic [OCC_W-1:0]       occ;
  logic [OCC_W-1:0]       occ_after_pop;
  logic [OCC_W-1:0]       occ_next;
  logic [OCC_W:0]         credit_used;
  logic                   cmd_legal;
  logic                   push;
  logic                   pop;
  logic                   push_last;
  logic                   final_handshake;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A command is rejected if it asks for nothing, for more words than the
  // BRAM holds, or starts outside the BRAM.
  assign cmd_legal = (count != '0)
                  && (count <= CNT_WIDTH'(RAM_DEPTH))
                  && ({1'b0, base_addr} < (ADDR_WIDTH + 1)'(RAM_DEPTH));

  // Credit: every read in the BRAM pipeline already owns a FIFO slot, so a
  // new read is only issued while pipeline tags plus stored words leave room.
  assign credit_used = (OCC_W + 1)'(occ) + (OCC_W + 1)'(tag1) + (OCC_W + 1)'(tag2);
  assign bram_en     = (state == READ) && (reads_remaining != '0)
                    && (credit_used < (OCC_W + 1)'(FIFO_DEPTH));
  assign bram_regce  = (state != IDLE);

  // The second tag marks the cycle in which bram_dout carries the word.
  assign push            = tag2;
  assign pop             = m_valid & m_ready;
  assign push_last       = (push_idx == cnt_q - CNT_WIDTH'(1));
  assign final_handshake = pop & m_last;
  assign occ_after_pop   = occ - OCC_W'(pop);
  assign occ_next        = occ_after_pop + OCC_W'(push);
  assign rd_ptr_next     = pop ? ptr_inc(rd_ptr) : rd_ptr;

  // Command sequencer: accepts commands in IDLE, walks the address range in
  // READ, and waits in DRAIN until the final beat has been handed off.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      bram_addr       <= '0;
      cnt_q           <= '0;
      reads_remaining <= '0;
      push_idx        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (push) begin
        push_idx <= push_idx + CNT_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (cmd_legal) begin
              state           <= READ;
              busy            <= 1'b1;
              bram_addr       <= base_addr;
              cnt_q           <= count;
              reads_remaining <= count;
              push_idx        <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          if (bram_en) begin
            reads_remaining <= reads_remaining - CNT_WIDTH'(1);
            bram_addr <= (bram_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0
                                                                  : bram_addr + ADDR_WIDTH'(1);
            if (reads_remaining == CNT_WIDTH'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (final_handshake) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline tags and FIFO bookkeeping. The head word is registered
  // directly into m_data: it comes from storage, or straight from bram_dout
  // when the word being pushed is the only one left after this cycle's pop.
  always_ff @(posedge clka) begin
    if (rsta) begin
      tag1    <= 1'b0;
      tag2    <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      tag1   <= bram_en;
      tag2   <= tag1;
      rd_ptr <= rd_ptr_next;
      occ    <= occ_next;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      m_valid <= (occ_next != '0);
      if (occ_next == '0) begin
        m_last <= 1'b0;
      end else if (occ_after_pop == '0) begin
        m_data <= bram_dout;
        m_last <= push_last;
      end else begin
        m_data <= fifo_data[rd_ptr_next];
        m_last <= fifo_last[rd_ptr_next];
      end
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clka) begin
    if (push) begin
      fifo_data[wr_ptr] <= bram_dout;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  // A push into a full FIFO without a matching pop would lose a word.
  fifo_no_overflow: assert property (@(posedge clka) disable iff (rsta)
    !(push && !pop && (occ == OCC_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_bias_bram_reader.sv
// tb_bias_bram_reader
// Self-checking bench for bias_bram_reader. A behavioural BRAM model feeds the
// DUT; a scoreboard of expected addresses and beats is filled when a command
// is issued and drained by an independent monitor on every read and handshake.
module tb_bias_bram_reader;

  localparam int RAM_WIDTH  = 40;
  localparam int RAM_DEPTH  = 49;
  localparam int ADDR_WIDTH = 6;
  localparam int CNT_WIDTH  = 7;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [RAM_WIDTH-1:0] data;
    logic                 last;
  } beat_t;

  logic                  clka = 1'b0;
  logic                  rsta;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic                  bram_en;
  logic                  bram_regce;
  logic [RAM_WIDTH-1:0]  bram_dout = '0;
  logic [RAM_WIDTH-1:0]  m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  logic [RAM_WIDTH-1:0]  bram_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0]  bram_latch = '0;

  beat_t                 expBeats [$];
  int                    expAddrs [$];
  int                    checks = 0;
  int                    passes = 0;
  int                    doneCount = 0;
  int                    errCount = 0;
  int                    beatsAccepted = 0;
  int                    outstanding = 0;
  bit                    stalled = 0;
  logic [RAM_WIDTH-1:0]  heldData;
  logic                  heldLast;
  bit                    randReady = 0;

  bias_bram_reader #(
    .RAM_WIDTH (RAM_WIDTH),
    .RAM_DEPTH (RAM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clka      (clka),
    .rsta      (rsta),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_regce(bram_regce),
    .bram_dout (bram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  // Free-running 10-unit clock.
  always #5 clka = ~clka;

  // BRAM port A model: address registered on ena, output register on regcea,
  // giving two cycles from address to douta.
  always @(posedge clka) begin
    if (bram_en) bram_latch <= bram_mem[bram_addr];
    if (bram_regce) bram_dout <= bram_latch;
  end

  // Random downstream readiness, only while the random phase enables it.
  always @(posedge clka) begin
    if (randReady) begin
      #1;
      m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit reached, passed=%0d total=%0d", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Drive one start strobe. When the command is expected to be accepted, the
  // reference model's address sequence and beats go into the scoreboard.
  task automatic applyStimulus(input int base, input int cnt, input bit expectAccept);
    beat_t b;
    int a;
    if (expectAccept) begin
      for (int i = 0; i < cnt; i++) begin
        a = (base + i) % RAM_DEPTH;
        expAddrs.push_back(a);
        b.data = bram_mem[a];
        b.last = (i == cnt - 1);
        expBeats.push_back(b);
      end
    end
    start     = 1'b1;
    base_addr = ADDR_WIDTH'(base);
    count     = CNT_WIDTH'(cnt);
    tick();
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done within budget", 64'(done), 64'(1));
    checkOutput("busy low with done", 64'(busy), 64'(0));
    checkOutput("beats outstanding", 64'(expBeats.size()), 64'(0));
    checkOutput("reads outstanding", 64'(expAddrs.size()), 64'(0));
  endtask

  // Monitor: checks every issued read against the expected address list and
  // the read credit, every handshake against the expected beat list, and that
  // a stalled beat holds still. Runs on the falling edge, away from the DUT.
  always @(negedge clka) begin
    beat_t expBeat;
    if (rsta) begin
      stalled     = 0;
      outstanding = 0;
    end else begin
      if (stalled) begin
        checkOutput("stall hold", 64'({m_valid, m_last, m_data}),
                    64'({1'b1, heldLast, heldData}));
      end
      if (bram_en) begin
        if (expAddrs.size() == 0) begin
          checkOutput("read without command", 64'(bram_en), 64'(0));
        end else begin
          checkOutput("bram_addr", 64'(bram_addr), 64'(expAddrs.pop_front()));
        end
        checkOutput("read credit", 64'(outstanding + 1 <= FIFO_DEPTH), 64'(1));
      end
      if (m_valid && m_ready) begin
        beatsAccepted++;
        if (expBeats.size() == 0) begin
          checkOutput("beat without command", 64'(m_valid), 64'(0));
        end else begin
          expBeat = expBeats.pop_front();
          checkOutput("m_data", 64'(m_data), 64'(expBeat.data));
          checkOutput("m_last", 64'(m_last), 64'(expBeat.last));
        end
      end
      outstanding = outstanding + int'(bram_en) - int'(m_valid && m_ready);
      stalled  = m_valid && !m_ready;
      heldData = m_data;
      heldLast = m_last;
      if (done) doneCount++;
      if (err) errCount++;
    end
  end

  // Directed scenarios first, then a randomized command stream.
  initial begin
    int doneBefore;
    int beatBase;
    int n;
    int b;
    int c;
    bit legal;
    logic [63:0] rnd;

    for (int i = 0; i < RAM_DEPTH; i++) bram_mem[i] = RAM_WIDTH'(32'h100 + i);
    rsta = 1'b1;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    m_ready = 1'b1;
    tick();
    tick();
    rsta = 1'b0;
    checkOutput("reset status", 64'({busy, done, err, bram_en, bram_regce, m_valid, m_last}), 64'(0));
    checkOutput("reset bram_addr", 64'(bram_addr), 64'(0));
    checkOutput("reset m_data", 64'(m_data), 64'(0));
    tick();

    // Basic read: cycle-accurate latency and framing.
    $display("[TB] basic read base=0 count=4");
    doneBefore = doneCount;
    applyStimulus(0, 4, 1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      checkOutput($sformatf("basic bram_en c%0d", cyc), 64'(bram_en), 64'(cyc <= 4));
      checkOutput($sformatf("basic m_valid c%0d", cyc), 64'(m_valid), 64'(cyc >= 4 && cyc <= 7));
      checkOutput($sformatf("basic m_last c%0d", cyc), 64'(m_last && m_valid), 64'(cyc == 7));
      checkOutput($sformatf("basic done c%0d", cyc), 64'(done), 64'(cyc == 8));
      checkOutput($sformatf("basic busy c%0d", cyc), 64'(busy), 64'(cyc < 8));
      checkOutput($sformatf("basic regce c%0d", cyc), 64'(bram_regce), 64'(cyc < 8));
      if (cyc < 8) tick();
    end
    tick();
    checkOutput("basic done count", 64'(doneCount - doneBefore), 64'(1));

    // Address wrap.
    $display("[TB] wrap base=47 count=4");
    applyStimulus(47, 4, 1);
    waitDone(100);
    tick();

    // Backpressure on a full-depth command.
    $display("[TB] backpressure base=0 count=49");
    applyStimulus(0, 49, 1);
    repeat (4) tick();
    m_ready = 1'b0;
    repeat (5) tick();
    checkOutput("stalled bram_en", 64'(bram_en), 64'(0));
    checkOutput("stalled m_valid", 64'(m_valid), 64'(1));
    repeat (5) tick();
    m_ready = 1'b1;
    waitDone(300);
    tick();

    // Illegal commands.
    $display("[TB] illegal commands");
    for (int k = 0; k < 3; k++) begin
      b = (k == 2) ? 49 : 0;
      c = (k == 0) ? 0 : ((k == 1) ? 50 : 1);
      applyStimulus(b, c, 0);
      checkOutput($sformatf("illegal%0d err", k), 64'(err), 64'(1));
      checkOutput($sformatf("illegal%0d busy", k), 64'(busy), 64'(0));
      tick();
      checkOutput($sformatf("illegal%0d err cleared", k), 64'(err), 64'(0));
      checkOutput($sformatf("illegal%0d still idle", k), 64'({busy, bram_en, bram_regce}), 64'(0));
      tick();
    end

    // Reset in the middle of a command.
    $display("[TB] reset mid-operation");
    doneBefore = doneCount;
    beatBase = beatsAccepted;
    applyStimulus(0, 10, 1);
    n = 0;
    while (beatsAccepted - beatBase < 2 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("two beats before reset", 64'(beatsAccepted - beatBase >= 2), 64'(1));
    rsta = 1'b1;
    expBeats.delete();
    expAddrs.delete();
    tick();
    rsta = 1'b0;
    checkOutput("mid-reset status", 64'({busy, done, err, bram_en, bram_regce, m_valid, m_last}), 64'(0));
    checkOutput("mid-reset bram_addr", 64'(bram_addr), 64'(0));
    checkOutput("mid-reset m_data", 64'(m_data), 64'(0));
    repeat (6) tick();
    checkOutput("no done after reset", 64'(doneCount - doneBefore), 64'(0));
    applyStimulus(5, 2, 1);
    waitDone(100);
    tick();

    // Start while busy is ignored.
    $display("[TB] start while busy");
    doneBefore = doneCount;
    applyStimulus(0, 8, 1);
    tick();
    tick();
    applyStimulus(20, 3, 0);
    waitDone(100);
    repeat (4) tick();
    checkOutput("single done pulse", 64'(doneCount - doneBefore), 64'(1));

    // Randomized commands against fresh random BRAM contents.
    $display("[TB] randomized commands");
    for (int i = 0; i < RAM_DEPTH; i++) begin
      rnd = {$urandom, $urandom};
      bram_mem[i] = rnd[RAM_WIDTH-1:0];
    end
    randReady = 1;
    for (int k = 0; k < 25; k++) begin
      b = $urandom_range(0, RAM_DEPTH - 1);
      c = $urandom_range(1, RAM_DEPTH);
      case ($urandom_range(0, 7))
        0: c = 0;
        1: c = $urandom_range(RAM_DEPTH + 1, 127);
        2: b = $urandom_range(RAM_DEPTH, 63);
        default: ;
      endcase
      legal = (c >= 1) && (c <= RAM_DEPTH) && (b < RAM_DEPTH);
      applyStimulus(b, c, legal);
      if (legal) begin
        checkOutput($sformatf("rand%0d busy", k), 64'(busy), 64'(1));
        waitDone(2000);
      end else begin
        checkOutput($sformatf("rand%0d err", k), 64'(err), 64'(1));
        checkOutput($sformatf("rand%0d busy", k), 64'(busy), 64'(0));
      end
      tick();
    end
    randReady = 0;
    m_ready = 1'b1;
    repeat (4) tick();
    checkOutput("final beats outstanding", 64'(expBeats.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
